// File: rtl/mesh_pkg.sv
// mesh_pkg: shared widths and packet type for mesh ejection endpoints
package mesh_pkg;
  localparam int QOS_W = 1;
  localparam int ID_W = 6;
  localparam int TYPE_W = 2;
  localparam int FLIT_W = 8;
  typedef struct packed {
    logic [QOS_W-1:0] qos;
    logic [TYPE_W-1:0] typ;
    logic [ID_W-1:0] src;
    logic [ID_W-1:0] tgt;
    logic [FLIT_W-1:0] data;
  } pkt_t;
endpackage

// File: rtl/pkt_ej_fifo.sv
// pkt_ej_fifo: per-class packet FIFO with extra-MSB pointers and a combinational head
module pkt_ej_fifo
  import mesh_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  pkt_t din,
  output pkt_t head,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  pkt_t mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/pkt_eject_rx.sv
// pkt_eject_rx: ejection endpoint with hi/lo QoS FIFOs, starvation-bounded arbitration and counters
module pkt_eject_rx
  import mesh_pkg::*;
#(
  parameter logic [ID_W-1:0] MY_ID = 6'd0,
  parameter int DEPTH = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pkt_out_vld,
  input  logic [QOS_W-1:0] pkt_out_qos,
  input  logic [TYPE_W-1:0] pkt_out_type,
  input  logic [ID_W-1:0] pkt_out_src,
  input  logic [ID_W-1:0] pkt_out_tgt,
  input  logic [FLIT_W-1:0] pkt_out_data,
  output logic pkt_out_rdy,
  output logic cons_vld,
  output logic [QOS_W-1:0] cons_qos,
  output logic [TYPE_W-1:0] cons_type,
  output logic [ID_W-1:0] cons_src,
  output logic [FLIT_W-1:0] cons_data,
  input  logic cons_rdy,
  output logic [15:0] rx_cnt,
  output logic [7:0] drop_cnt,
  output logic err_misroute
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  pkt_t in_pkt, hi_head, lo_head, out_pkt;
  logic hi_full, hi_empty, lo_full, lo_empty;
  logic acc, mine, hi_push, lo_push, hi_pop, lo_pop;
  logic fresh_lo, sel_lo, locked, locked_lo;
  logic [SW-1:0] starve_cnt;
  assign in_pkt = '{pkt_out_qos, pkt_out_type, pkt_out_src, pkt_out_tgt, pkt_out_data};
  assign pkt_out_rdy = !hi_full && !lo_full;
  assign acc = pkt_out_vld && pkt_out_rdy;
  assign mine = pkt_out_tgt == MY_ID;
  assign hi_push = acc && mine && pkt_out_qos[0];
  assign lo_push = acc && mine && !pkt_out_qos[0];
  assign cons_vld = !hi_empty || !lo_empty;
  // a stalled presentation keeps its class even if the other FIFO changes underneath it
  assign fresh_lo = !lo_empty && (hi_empty || starve_cnt == SW'(STARVE_MAX));
  assign sel_lo = locked ? locked_lo : fresh_lo;
  assign out_pkt = !cons_vld ? '0 : sel_lo ? lo_head : hi_head;
  assign hi_pop = cons_vld && cons_rdy && !sel_lo;
  assign lo_pop = cons_vld && cons_rdy && sel_lo;
  assign cons_qos = out_pkt.qos;
  assign cons_type = out_pkt.typ;
  assign cons_src = out_pkt.src;
  assign cons_data = out_pkt.data;
  pkt_ej_fifo #(.DEPTH(DEPTH)) u_hi (
    .clk(clk), .rst(rst), .push(hi_push), .pop(hi_pop), .din(in_pkt),
    .head(hi_head), .full(hi_full), .empty(hi_empty)
  );
  pkt_ej_fifo #(.DEPTH(DEPTH)) u_lo (
    .clk(clk), .rst(rst), .push(lo_push), .pop(lo_pop), .din(in_pkt),
    .head(lo_head), .full(lo_full), .empty(lo_empty)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt <= '0;
      drop_cnt <= '0;
      err_misroute <= 1'b0;
      starve_cnt <= '0;
      locked <= 1'b0;
      locked_lo <= 1'b0;
    end else begin
      locked <= cons_vld && !cons_rdy;
      locked_lo <= sel_lo;
      if (acc && mine && rx_cnt != '1) rx_cnt <= rx_cnt + 1'b1;
      if (acc && !mine && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      if (acc && !mine) err_misroute <= 1'b1;
      starve_cnt <= (lo_pop || lo_empty) ? '0 : hi_pop ? starve_cnt + 1'b1 : starve_cnt;
    end
  end
endmodule
